// File: rtl/exception_sequencer_pkg.sv
// Shared encodings for the exception sequencer: FSM states, target kinds,
// status-register-file select codes and vector offsets.
package exception_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAVE    = 3'd1,
      ST_SWITCH  = 3'd2,
      ST_LINK    = 3'd3,
      ST_RESTORE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      TGT_FIQ = 2'd0,
      TGT_IRQ = 2'd1,
      TGT_UND = 2'd2,
      TGT_SVC = 2'd3
   } tgt_e;

   // Change_M bank-select codes
   localparam logic [2:0] MODE_CUR = 3'd0;
   localparam logic [2:0] MODE_FIQ = 3'd1;
   localparam logic [2:0] MODE_IRQ = 3'd2;
   localparam logic [2:0] MODE_SVC = 3'd3;
   localparam logic [2:0] MODE_UND = 3'd4;

   // W_CPSR_s source-select codes
   localparam logic [2:0] SEL_SPSR = 3'd0;
   localparam logic [2:0] SEL_IRQ  = 3'd2;
   localparam logic [2:0] SEL_FIQ  = 3'd3;
   localparam logic [2:0] SEL_SVC  = 3'd4;
   localparam logic [2:0] SEL_UND  = 3'd5;

   localparam logic [31:0] VOFF_UND = 32'h0000_0004;
   localparam logic [31:0] VOFF_SVC = 32'h0000_0008;
   localparam logic [31:0] VOFF_IRQ = 32'h0000_0018;
   localparam logic [31:0] VOFF_FIQ = 32'h0000_001C;

   function automatic logic [2:0] mode_code(tgt_e t);
      case (t)
         TGT_FIQ: mode_code = MODE_FIQ;
         TGT_IRQ: mode_code = MODE_IRQ;
         TGT_UND: mode_code = MODE_UND;
         default: mode_code = MODE_SVC;
      endcase
   endfunction

   function automatic logic [2:0] cpsr_sel(tgt_e t);
      case (t)
         TGT_FIQ: cpsr_sel = SEL_FIQ;
         TGT_IRQ: cpsr_sel = SEL_IRQ;
         TGT_UND: cpsr_sel = SEL_UND;
         default: cpsr_sel = SEL_SVC;
      endcase
   endfunction

   function automatic logic [31:0] vec_offset(tgt_e t);
      case (t)
         TGT_FIQ: vec_offset = VOFF_FIQ;
         TGT_IRQ: vec_offset = VOFF_IRQ;
         TGT_UND: vec_offset = VOFF_UND;
         default: vec_offset = VOFF_SVC;
      endcase
   endfunction

endpackage

// File: rtl/exception_sequencer_sync_2ff.sv
// Flop-chain synchroniser for asynchronous level inputs; depth set by STAGES (>= 2).
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= {chain_q[STAGES-2:0], d_i};
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer producing SPSR/CPSR/LR/PC write controls
// for the status register file; every output is a registered copy of the next state.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | no sequence; arbitrate at instruction boundaries
//   ST_SAVE    | bank CPSR into target-mode SPSR
//   ST_SWITCH  | load CPSR with target mode/mask
//   ST_LINK    | write banked LR = epc+4, load vector PC
//   ST_RESTORE | CPSR <- current-mode SPSR (exception return)
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter logic [31:0] VEC_BASE    = 32'h0000_0000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq,
   input  logic        fiq,
   input  logic        und_req,
   input  logic        svc_req,
   input  logic        eret_req,
   input  logic        boundary,
   input  logic [1:0]  cpsr_if,
   input  logic [31:0] epc,
   output logic        W_SPSR_s,
   output logic        Write_SPSR,
   output logic [2:0]  W_CPSR_s,
   output logic        Write_CPSR,
   output logic [2:0]  Change_M,
   output logic        lr_we,
   output logic [31:0] lr_data,
   output logic        pc_load,
   output logic [31:0] pc_vector,
   output logic        stall,
   output logic        busy
);

   logic irq_s, fiq_s;

   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_irq (.clk(clk), .rst_n(rst_n), .d_i(irq), .q_o(irq_s));
   sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_fiq (.clk(clk), .rst_n(rst_n), .d_i(fiq), .q_o(fiq_s));

   state_e      state_q, state_d;
   tgt_e        tgt_q, tgt_d;
   logic [31:0] epc_q, epc_d;
   logic        und_p_q, und_p_d, svc_p_q, svc_p_d, eret_p_q, eret_p_d;
   logic        take_und, take_svc, take_eret;
   logic        fiq_ok, irq_ok;

   assign fiq_ok = fiq_s & ~cpsr_if[0];
   assign irq_ok = irq_s & ~cpsr_if[1];

   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      epc_d     = epc_q;
      take_und  = 1'b0;
      take_svc  = 1'b0;
      take_eret = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (boundary) begin
               if (eret_p_q) begin
                  state_d   = ST_RESTORE;
                  take_eret = 1'b1;
               end else if (fiq_ok || irq_ok || und_p_q || svc_p_q) begin
                  state_d = ST_SAVE;
                  epc_d   = epc;
                  if (fiq_ok)       tgt_d = TGT_FIQ;
                  else if (irq_ok)  tgt_d = TGT_IRQ;
                  else if (und_p_q) begin
                     tgt_d    = TGT_UND;
                     take_und = 1'b1;
                  end else begin
                     tgt_d    = TGT_SVC;
                     take_svc = 1'b1;
                  end
               end
            end
         end
         ST_SAVE:   state_d = ST_SWITCH;
         ST_SWITCH: state_d = ST_LINK;
         default:   state_d = ST_IDLE;
      endcase
   end

   // A fresh pulse re-arms the latch even in the cycle the old request is taken.
   assign und_p_d  = und_req  | (und_p_q  & ~take_und);
   assign svc_p_d  = svc_req  | (svc_p_q  & ~take_svc);
   assign eret_p_d = eret_req | (eret_p_q & ~take_eret);

   logic        w_spsr_s_d, write_spsr_d, write_cpsr_d, lr_we_d, pc_load_d, busy_d;
   logic [2:0]  w_cpsr_s_d, change_m_d;
   logic [31:0] lr_data_d, pc_vector_d;

   always_comb begin
      w_spsr_s_d   = 1'b0;
      write_spsr_d = 1'b0;
      w_cpsr_s_d   = SEL_SPSR;
      write_cpsr_d = 1'b0;
      change_m_d   = MODE_CUR;
      lr_we_d      = 1'b0;
      lr_data_d    = '0;
      pc_load_d    = 1'b0;
      pc_vector_d  = '0;
      busy_d       = (state_d != ST_IDLE);
      case (state_d)
         ST_SAVE: begin
            change_m_d   = mode_code(tgt_d);
            w_spsr_s_d   = 1'b1;
            write_spsr_d = 1'b1;
         end
         ST_SWITCH: begin
            w_cpsr_s_d   = cpsr_sel(tgt_d);
            write_cpsr_d = 1'b1;
         end
         ST_LINK: begin
            lr_we_d     = 1'b1;
            lr_data_d   = epc_q + 32'd4;
            pc_load_d   = 1'b1;
            pc_vector_d = VEC_BASE + vec_offset(tgt_d);
         end
         ST_RESTORE: write_cpsr_d = 1'b1;
         default: ;
      endcase
   end

   logic        w_spsr_s_q, write_spsr_q, write_cpsr_q, lr_we_q, pc_load_q, busy_q;
   logic [2:0]  w_cpsr_s_q, change_m_q;
   logic [31:0] lr_data_q, pc_vector_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tgt_q        <= TGT_FIQ;
         epc_q        <= '0;
         und_p_q      <= 1'b0;
         svc_p_q      <= 1'b0;
         eret_p_q     <= 1'b0;
         w_spsr_s_q   <= 1'b0;
         write_spsr_q <= 1'b0;
         w_cpsr_s_q   <= '0;
         write_cpsr_q <= 1'b0;
         change_m_q   <= '0;
         lr_we_q      <= 1'b0;
         lr_data_q    <= '0;
         pc_load_q    <= 1'b0;
         pc_vector_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         epc_q        <= epc_d;
         und_p_q      <= und_p_d;
         svc_p_q      <= svc_p_d;
         eret_p_q     <= eret_p_d;
         w_spsr_s_q   <= w_spsr_s_d;
         write_spsr_q <= write_spsr_d;
         w_cpsr_s_q   <= w_cpsr_s_d;
         write_cpsr_q <= write_cpsr_d;
         change_m_q   <= change_m_d;
         lr_we_q      <= lr_we_d;
         lr_data_q    <= lr_data_d;
         pc_load_q    <= pc_load_d;
         pc_vector_q  <= pc_vector_d;
         busy_q       <= busy_d;
      end
   end

   assign W_SPSR_s   = w_spsr_s_q;
   assign Write_SPSR = write_spsr_q;
   assign W_CPSR_s   = w_cpsr_s_q;
   assign Write_CPSR = write_cpsr_q;
   assign Change_M   = change_m_q;
   assign lr_we      = lr_we_q;
   assign lr_data    = lr_data_q;
   assign pc_load    = pc_load_q;
   assign pc_vector  = pc_vector_q;
   assign stall      = busy_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: directed scenarios plus a
// randomized run scored against a priority/pending reference model.
module tb_exception_sequencer;

   localparam int          SYNC = 2;
   localparam logic [31:0] VEC  = 32'h0000_0000;
   localparam int K_NONE = 0, K_FIQ = 1, K_IRQ = 2, K_UND = 3, K_SVC = 4, K_ERET = 5;

   logic        clk = 1'b0;
   logic        rst_n, irq, fiq, und_req, svc_req, eret_req, boundary;
   logic [1:0]  cpsr_if;
   logic [31:0] epc;
   logic        W_SPSR_s, Write_SPSR, Write_CPSR, lr_we, pc_load, stall, busy;
   logic [2:0]  W_CPSR_s, Change_M;
   logic [31:0] lr_data, pc_vector;

   int pass_cnt = 0;
   int total_cnt = 0;

   exception_sequencer #(.VEC_BASE(VEC), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .irq(irq), .fiq(fiq), .und_req(und_req),
      .svc_req(svc_req), .eret_req(eret_req), .boundary(boundary),
      .cpsr_if(cpsr_if), .epc(epc), .W_SPSR_s(W_SPSR_s), .Write_SPSR(Write_SPSR),
      .W_CPSR_s(W_CPSR_s), .Write_CPSR(Write_CPSR), .Change_M(Change_M),
      .lr_we(lr_we), .lr_data(lr_data), .pc_load(pc_load), .pc_vector(pc_vector),
      .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   wire [76:0] obs = {W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Change_M,
                      lr_we, lr_data, pc_load, pc_vector, stall, busy};

   // Expected output word for one cycle of a sequence of the given kind.
   function automatic logic [76:0] exp_vec(int kind, int phase, logic [31:0] e);
      logic wss, ws, wc, lw, pl, st;
      logic [2:0] cs, cm, mode, sel;
      logic [31:0] lr, pv, off;
      wss = 0; ws = 0; wc = 0; lw = 0; pl = 0; st = 0;
      cs = 0; cm = 0; lr = 0; pv = 0;
      case (kind)
         K_FIQ:   begin mode = 3'd1; sel = 3'd3; off = 32'h1C; end
         K_IRQ:   begin mode = 3'd2; sel = 3'd2; off = 32'h18; end
         K_UND:   begin mode = 3'd4; sel = 3'd5; off = 32'h04; end
         default: begin mode = 3'd3; sel = 3'd4; off = 32'h08; end
      endcase
      if (kind == K_ERET) begin
         if (phase == 0) begin wc = 1; st = 1; end
      end else if (kind != K_NONE) begin
         case (phase)
            0: begin wss = 1; ws = 1; cm = mode; st = 1; end
            1: begin cs = sel; wc = 1; st = 1; end
            2: begin lw = 1; lr = e + 32'd4; pl = 1; pv = VEC + off; st = 1; end
            default: ;
         endcase
      end
      return {wss, ws, cs, wc, cm, lw, lr, pl, pv, st, st};
   endfunction

   // Waits for busy (bounded), then records nph consecutive cycles.
   // epc is scrambled after entry so a design using live epc for LR shows up.
   task automatic capture(input int nph, input int budget,
                          output logic [3:0][76:0] v, output bit found);
      found = 0;
      v = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin found = 1; break; end
      end
      if (found) begin
         v[0] = obs;
         epc = $urandom;
         for (int p = 1; p < nph; p++) begin
            @(negedge clk);
            v[p] = obs;
         end
      end
   endtask

   task automatic pulse(input bit u, input bit s, input bit e);
      @(negedge clk);
      und_req = u; svc_req = s; eret_req = e;
      @(negedge clk);
      und_req = 0; svc_req = 0; eret_req = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 0; irq = 0; fiq = 0; und_req = 0; svc_req = 0; eret_req = 0;
      boundary = 0; cpsr_if = 2'b11; epc = 0;
      #12;
      total_cnt++;
      if (obs !== 77'd0) $display("FAIL reset_outputs: got %h expected 0", obs);
      else pass_cnt++;
      @(negedge clk); rst_n = 1;
      idle_cycles(2);
      total_cnt++;
      if (obs !== 77'd0) $display("FAIL post_reset_idle: got %h expected 0", obs);
      else pass_cnt++;
   endtask

   task automatic test_irq_entry_and_nest;
      logic [3:0][76:0] v; bit found;
      cpsr_if = 2'b00; irq = 1; epc = 32'h100; boundary = 1;
      capture(4, 10, v, found);
      total_cnt++;
      if (!found) $display("FAIL irq_entry_timeout: busy=%b expected 1", busy);
      else pass_cnt++;
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_IRQ, p, 32'h100))
            $display("FAIL irq_entry phase%0d: got %h expected %h", p, v[p], exp_vec(K_IRQ, p, 32'h100));
         else pass_cnt++;
      end
      cpsr_if = 2'b10;
      epc = 32'h0000_0400;
      fiq = 1;
      capture(4, 10, v, found);
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_FIQ, p, 32'h400))
            $display("FAIL nested_fiq phase%0d: got %h expected %h", p, v[p], exp_vec(K_FIQ, p, 32'h400));
         else pass_cnt++;
      end
      cpsr_if = 2'b11; irq = 0; fiq = 0;
      idle_cycles(SYNC + 2);
   endtask

   task automatic test_fiq_irq_together;
      logic [3:0][76:0] v; bit found; int busy_seen;
      boundary = 0; cpsr_if = 2'b00; irq = 1; fiq = 1; epc = 32'h0000_0840;
      idle_cycles(SYNC + 1);
      boundary = 1;
      capture(4, 6, v, found);
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_FIQ, p, 32'h840))
            $display("FAIL fiq_first phase%0d: got %h expected %h", p, v[p], exp_vec(K_FIQ, p, 32'h840));
         else pass_cnt++;
      end
      cpsr_if = 2'b11;
      busy_seen = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen++; end
      total_cnt++;
      if (busy_seen != 0) $display("FAIL irq_masked_after_fiq: busy cycles %0d expected 0", busy_seen);
      else pass_cnt++;
      irq = 0; fiq = 0;
      idle_cycles(SYNC + 2);
   endtask

   task automatic test_und_svc_same_cycle;
      logic [3:0][76:0] v; bit found;
      boundary = 1; epc = 32'h200;
      pulse(1, 1, 0);
      capture(4, 6, v, found);
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_UND, p, 32'h200))
            $display("FAIL und_first phase%0d: got %h expected %h", p, v[p], exp_vec(K_UND, p, 32'h200));
         else pass_cnt++;
      end
      epc = 32'hFFFF_FFFC;
      capture(4, 6, v, found);
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_SVC, p, 32'hFFFF_FFFC))
            $display("FAIL svc_after_und_wrap phase%0d: got %h expected %h", p, v[p], exp_vec(K_SVC, p, 32'hFFFF_FFFC));
         else pass_cnt++;
      end
   endtask

   task automatic test_masking;
      logic [3:0][76:0] v; bit found; int busy_seen;
      boundary = 1; cpsr_if = 2'b10; irq = 1; epc = 32'h0000_1230;
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen++; end
      total_cnt++;
      if (busy_seen != 0) $display("FAIL irq_masked_hold: busy cycles %0d expected 0", busy_seen);
      else pass_cnt++;
      cpsr_if = 2'b00;
      capture(4, SYNC + 1, v, found);
      total_cnt++;
      if (!found) $display("FAIL unmask_latency: no entry within %0d cycles", SYNC + 1);
      else pass_cnt++;
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_IRQ, p, 32'h1230))
            $display("FAIL unmask_irq phase%0d: got %h expected %h", p, v[p], exp_vec(K_IRQ, p, 32'h1230));
         else pass_cnt++;
      end
      cpsr_if = 2'b10; irq = 0;
      idle_cycles(SYNC + 2);
   endtask

   task automatic test_eret;
      logic [3:0][76:0] v; bit found;
      boundary = 0; epc = 32'h0000_0A00;
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      boundary = 1;
      capture(2, 6, v, found);
      for (int p = 0; p < 2; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_ERET, p, 32'h0))
            $display("FAIL eret_restore phase%0d: got %h expected %h", p, v[p], exp_vec(K_ERET, p, 32'h0));
         else pass_cnt++;
      end
      epc = 32'h0000_0B00;
      capture(4, 6, v, found);
      for (int p = 0; p < 4; p++) begin
         total_cnt++;
         if (v[p] !== exp_vec(K_SVC, p, 32'hB00))
            $display("FAIL svc_after_eret phase%0d: got %h expected %h", p, v[p], exp_vec(K_SVC, p, 32'hB00));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_sequence;
      bit found; int busy_seen;
      boundary = 1; irq = 0; fiq = 0; epc = 32'h300;
      pulse(1, 1, 0);
      found = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin found = 1; break; end
      end
      @(negedge clk);
      total_cnt++;
      if (!found || Write_CPSR !== 1'b1 || W_CPSR_s !== 3'd5)
         $display("FAIL reach_switch: found=%0b Write_CPSR=%b W_CPSR_s=%0d expected 1/1/5", found, Write_CPSR, W_CPSR_s);
      else pass_cnt++;
      #1 rst_n = 0;
      #1;
      total_cnt++;
      if (obs !== 77'd0) $display("FAIL async_reset_outputs: got %h expected 0", obs);
      else pass_cnt++;
      @(negedge clk); rst_n = 1;
      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen++; end
      total_cnt++;
      if (busy_seen != 0) $display("FAIL pending_cleared_by_reset: busy cycles %0d expected 0", busy_seen);
      else pass_cnt++;
   endtask

   // Reference model: pending set + levels + mask -> priority winner, service by service.
   task automatic test_random;
      logic [3:0][76:0] v; bit found; int busy_seen, win, nph;
      bit p_und, p_svc, p_eret, l_irq, l_fiq, m_i, m_f;
      logic [31:0] e;
      for (int it = 0; it < 40; it++) begin
         boundary = 0;
         l_irq = 1'($urandom_range(0, 1)); l_fiq = 1'($urandom_range(0, 1));
         m_i = 1'($urandom_range(0, 1));   m_f = 1'($urandom_range(0, 1));
         p_und = 1'($urandom_range(0, 1)); p_svc = 1'($urandom_range(0, 1));
         p_eret = 1'($urandom_range(0, 1));
         irq = l_irq; fiq = l_fiq; cpsr_if = {m_i, m_f};
         pulse(p_und, p_svc, p_eret);
         idle_cycles(SYNC + 1);
         for (int s = 0; s < 6; s++) begin
            if (p_eret) win = K_ERET;
            else if (l_fiq && !m_f) win = K_FIQ;
            else if (l_irq && !m_i) win = K_IRQ;
            else if (p_und) win = K_UND;
            else if (p_svc) win = K_SVC;
            else win = K_NONE;
            e = $urandom;
            epc = e;
            if (s == 0) boundary = 1;
            if (win == K_NONE) begin
               busy_seen = 0;
               for (int i = 0; i < SYNC + 3; i++) begin @(negedge clk); if (busy !== 1'b0) busy_seen++; end
               total_cnt++;
               if (busy_seen != 0) $display("FAIL rand%0d_spurious_entry: busy cycles %0d expected 0", it, busy_seen);
               else pass_cnt++;
               break;
            end
            nph = (win == K_ERET) ? 2 : 4;
            capture(nph, 6, v, found);
            total_cnt++;
            if (!found) $display("FAIL rand%0d_timeout kind %0d: busy=%b expected 1", it, win, busy);
            else pass_cnt++;
            for (int p = 0; p < nph; p++) begin
               total_cnt++;
               if (v[p] !== exp_vec(win, p, e))
                  $display("FAIL rand%0d kind%0d phase%0d: got %h expected %h", it, win, p, v[p], exp_vec(win, p, e));
               else pass_cnt++;
            end
            case (win)
               K_ERET: p_eret = 0;
               K_UND:  begin p_und = 0; m_i = 1; end
               K_SVC:  begin p_svc = 0; m_i = 1; end
               K_IRQ:  m_i = 1;
               K_FIQ:  begin m_i = 1; m_f = 1; end
               default: ;
            endcase
            cpsr_if = {m_i, m_f};
         end
         boundary = 0; irq = 0; fiq = 0;
         idle_cycles(SYNC + 2);
      end
   endtask

   initial begin
      test_reset;
      test_irq_entry_and_nest;
      test_fiq_irq_together;
      test_und_svc_same_cycle;
      test_masking;
      test_eret;
      test_reset_mid_sequence;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
